// File: rtl/wb_uart_pkg.sv
// Shared constants and types for the Wishbone UART transmitter.
package wb_uart_pkg;

    localparam int unsigned WB_DW   = 32;
    localparam int unsigned WB_AW   = 32;
    localparam int unsigned WB_SW   = 4;
    localparam int unsigned DIV_W   = 16;
    localparam int unsigned BYTE_W  = 8;

    // Register offsets, decoded from adr[3:2]
    localparam logic [1:0] TXDATA = 2'd0;
    localparam logic [1:0] STATUS = 2'd1;
    localparam logic [1:0] DIV    = 2'd2;
    localparam logic [1:0] CTRL   = 2'd3;

    // STATUS bit positions
    localparam int unsigned ST_FULL  = 0;
    localparam int unsigned ST_EMPTY = 1;
    localparam int unsigned ST_BUSY  = 2;
    localparam int unsigned ST_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/wb_uart_if.sv
// Pipelined Wishbone bus bundle (32-bit data, byte address).
interface wb_if;
    import wb_uart_pkg::*;

    logic             cyc;
    logic             stb;
    logic             we;
    logic [WB_SW-1:0] sel;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat_m;
    logic [WB_DW-1:0] dat_s;
    logic             ack;
    logic             stall;
    logic             err;

    modport master (output cyc, stb, we, sel, adr, dat_m,
                    input  dat_s, ack, stall, err);

    modport slave  (input  cyc, stb, we, sel, adr, dat_m,
                    output dat_s, ack, stall, err);

endinterface

// File: rtl/wb_uart_fifo.sv
// Synchronous byte FIFO with extra-bit pointers; push and pop may coincide at full or empty.
module wb_uart_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push_c;
    logic             do_pop_c;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop_c  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push_c = push && (!full || do_pop_c);
    assign dout      = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone slave UART transmitter: register decode, TX FIFO and 8N1 serialiser.
module wb_uart_tx
    import wb_uart_pkg::*;
#(
    parameter int unsigned DIVISOR    = 868,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    wb_if.slave  wb,
    output logic txd,
    output logic irq
);

    logic              xfer_c;
    logic              wr_c;
    logic              rd_c;
    logic [1:0]        reg_c;
    logic              push_c;
    logic              pop_c;
    logic              busy_c;
    logic [WB_DW-1:0]  rdata_c;
    logic              fifo_full;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_dout;

    logic              ovf;
    logic              ie;
    logic [DIV_W-1:0]  div;

    tx_state_t         state;
    tx_state_t         state_d;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  cnt_d;
    logic [DIV_W-1:0]  div_lat;
    logic [DIV_W-1:0]  div_lat_d;
    logic [BYTE_W-1:0] shift;
    logic [BYTE_W-1:0] shift_d;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_d;
    logic              txd_d;

    logic              unused_c;

    assign xfer_c    = wb.cyc & wb.stb;
    assign wr_c      = xfer_c & wb.we;
    assign rd_c      = xfer_c & ~wb.we;
    assign reg_c     = wb.adr[3:2];
    assign push_c    = wr_c && (reg_c == TXDATA);
    assign busy_c    = (state != IDLE);
    assign wb.stall  = 1'b0;
    assign wb.err    = 1'b0;
    assign unused_c  = ^{wb.sel, wb.adr[WB_AW-1:4], wb.adr[1:0], wb.dat_m[WB_DW-1:DIV_W]};

    wb_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .din   (wb.dat_m[BYTE_W-1:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Read mux; sampled into dat_s so reads see the state before this cycle's write.
    always_comb begin
        rdata_c = '0;
        case (reg_c)
            STATUS: begin
                rdata_c[ST_FULL]  = fifo_full;
                rdata_c[ST_EMPTY] = fifo_empty;
                rdata_c[ST_BUSY]  = busy_c;
                rdata_c[ST_OVF]   = ovf;
            end
            DIV:     rdata_c[DIV_W-1:0] = div;
            CTRL:    rdata_c[0] = ie;
            default: rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb.ack   <= 1'b0;
            wb.dat_s <= '0;
            irq      <= 1'b0;
            ovf      <= 1'b0;
            ie       <= 1'b0;
            div      <= DIV_W'(DIVISOR);
        end else begin
            wb.ack   <= xfer_c;
            wb.dat_s <= rd_c ? rdata_c : '0;
            irq      <= ie & fifo_empty & ~busy_c;
            if (push_c && fifo_full && !pop_c) begin
                ovf <= 1'b1;
            end else if (wr_c && (reg_c == STATUS) && wb.dat_m[ST_OVF]) begin
                ovf <= 1'b0;
            end
            if (wr_c && (reg_c == DIV)) begin
                div <= (wb.dat_m[DIV_W-1:0] == '0) ? DIV_W'(1) : wb.dat_m[DIV_W-1:0];
            end
            if (wr_c && (reg_c == CTRL)) ie <= wb.dat_m[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            div_lat <= '0;
            shift   <= '0;
            bit_idx <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            div_lat <= div_lat_d;
            shift   <= shift_d;
            bit_idx <= bit_idx_d;
            txd     <= txd_d;
        end
    end

    // cnt holds the clocks remaining in the current bit; txd_d is the level for the next cycle.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        div_lat_d = div_lat;
        shift_d   = shift;
        bit_idx_d = bit_idx;
        txd_d     = txd;
        pop_c     = 1'b0;
        case (state)
            IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop_c     = 1'b1;
                    shift_d   = fifo_dout;
                    div_lat_d = div;
                    cnt_d     = div - DIV_W'(1);
                    txd_d     = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    state_d   = DATA;
                    cnt_d     = div_lat - DIV_W'(1);
                    bit_idx_d = 3'd0;
                    txd_d     = shift[0];
                end else begin
                    cnt_d = cnt - DIV_W'(1);
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    cnt_d = div_lat - DIV_W'(1);
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                        shift_d   = {1'b0, shift[BYTE_W-1:1]};
                        txd_d     = shift[1];
                    end
                end else begin
                    cnt_d = cnt - DIV_W'(1);
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Randomised bench for wb_uart_tx against a timeline model of frame schedules.
module tb_wb_uart_tx;
    import wb_uart_pkg::*;

    localparam int unsigned DIVISOR = 868;
    localparam int unsigned DEPTH   = 16;

    logic clk = 1'b0;
    logic rst;
    logic txd;
    logic irq;

    wb_if wb ();

    wb_uart_tx #(
        .DIVISOR    (DIVISOR),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb),
        .txd (txd),
        .irq (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: every accepted byte gets a start edge s = max(push+1, previous s + 10*P + 1),
    // where P is the DIV value written at an edge before s.
    int         push_e[$];
    logic [7:0] push_b[$];
    int         st[$];
    int         per[$];
    int         dw_e[$];
    int         dw_v[$];
    int         base_free = 0;
    int         edge_no   = 0;
    bit         m_ovf, m_ie, started, m_rst;
    bit         exp_ack, exp_rd, exp_irq;
    logic [31:0] exp_dat;
    logic [1:0] m_reg;
    int         m_x;
    int         m_q;

    function automatic int div_at(input int s);
        for (int i = dw_e.size() - 1; i >= 0; i--) begin
            if (dw_e[i] < s) return dw_v[i];
        end
        return DIVISOR;
    endfunction

    function automatic void resched();
        int fr;
        int s;
        fr = base_free;
        st.delete();
        per.delete();
        for (int i = 0; i < push_e.size(); i++) begin
            s = (push_e[i] + 1 > fr) ? push_e[i] + 1 : fr;
            st.push_back(s);
            per.push_back(div_at(s));
            fr = s + 10 * div_at(s) + 1;
        end
    endfunction

    function automatic void prune();
        while (st.size() > 0 && st[0] + 10 * per[0] + 1 < edge_no - 1) begin
            base_free = st[0] + 10 * per[0] + 1;
            void'(st.pop_front());
            void'(per.pop_front());
            void'(push_e.pop_front());
            void'(push_b.pop_front());
        end
    endfunction

    function automatic int occ_at(input int x);
        int c = 0;
        for (int i = 0; i < st.size(); i++) if (push_e[i] <= x && st[i] > x) c++;
        return c;
    endfunction

    function automatic bit busy_at(input int x);
        for (int i = 0; i < st.size(); i++) if (x >= st[i] && x < st[i] + 10 * per[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic txd_at(input int x);
        int k;
        for (int i = 0; i < st.size(); i++) begin
            if (x >= st[i] && x < st[i] + 10 * per[i]) begin
                k = (x - st[i]) / per[i];
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return push_b[i][k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic bit model_idle();
        return (occ_at(edge_no) == 0) && !busy_at(edge_no);
    endfunction

    // Advance the model by one clock edge using the bus/reset values the DUT samples.
    always @(posedge clk) begin
        edge_no++;
        resched();
        m_rst = rst;
        if (rst) begin
            push_e.delete(); push_b.delete(); st.delete(); per.delete();
            dw_e.delete(); dw_v.delete();
            base_free = 0;
            m_ovf = 1'b0; m_ie = 1'b0;
            exp_ack = 1'b0; exp_rd = 1'b0; exp_irq = 1'b0;
            started = 1'b1;
        end else begin
            m_x     = edge_no - 1;
            exp_irq = m_ie && (occ_at(m_x) == 0) && !busy_at(m_x);
            exp_ack = wb.cyc && wb.stb;
            exp_rd  = exp_ack && !wb.we;
            m_reg   = wb.adr[3:2];
            if (exp_rd) begin
                exp_dat = '0;
                case (m_reg)
                    STATUS:  exp_dat = {28'd0, m_ovf, busy_at(m_x), occ_at(m_x) == 0, occ_at(m_x) == DEPTH};
                    DIV:     exp_dat = 32'(div_at(edge_no));
                    CTRL:    exp_dat = {31'd0, m_ie};
                    default: exp_dat = '0;
                endcase
            end else if (exp_ack) begin
                case (m_reg)
                    TXDATA: begin
                        m_q = 0;
                        for (int i = 0; i < st.size(); i++) if (st[i] > edge_no) m_q++;
                        if (m_q < DEPTH) begin
                            push_e.push_back(edge_no);
                            push_b.push_back(wb.dat_m[7:0]);
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                    STATUS: if (wb.dat_m[3]) m_ovf = 1'b0;
                    DIV: begin
                        dw_e.push_back(edge_no);
                        dw_v.push_back((wb.dat_m[15:0] == 16'd0) ? 1 : int'(wb.dat_m[15:0]));
                    end
                    default: m_ie = wb.dat_m[0];
                endcase
            end
        end
        resched();
        prune();
    end

    always @(negedge clk) begin
        if (started) begin
            check("ack", 32'(wb.ack), 32'(exp_ack));
            if (exp_rd) check("rdata", wb.dat_s, exp_dat);
            if (m_rst)  check("rst_dat_s", wb.dat_s, 32'd0);
            check("txd", 32'(txd), 32'(txd_at(edge_no)));
            check("irq", 32'(irq), 32'(exp_irq));
            check("stall_err", {30'd0, wb.stall, wb.err}, 32'd0);
        end
    end

    task automatic bus(input bit we, input logic [1:0] r, input logic [31:0] d);
        wb.cyc   = 1'b1;
        wb.stb   = 1'b1;
        wb.we    = we;
        wb.sel   = 4'($urandom);
        wb.adr   = {28'($urandom), r, 2'($urandom)};
        wb.dat_m = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        wb.stb = 1'b0;
        wb.cyc = 1'($urandom);
        wb.we  = 1'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        idle(1);
        while (!model_idle() && k < budget) begin
            idle(1);
            k++;
        end
        check("wait_idle", 32'(model_idle()), 32'd1);
    endtask

    int op;

    initial begin
        rst      = 1'b1;
        wb.cyc   = 1'b0;
        wb.stb   = 1'b0;
        wb.we    = 1'b0;
        wb.sel   = '0;
        wb.adr   = '0;
        wb.dat_m = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state read-back
        bus(1'b0, STATUS, 32'd0);
        idle(2);

        // 0x55 at four clocks per bit
        bus(1'b1, DIV, 32'd4);
        bus(1'b1, TXDATA, 32'h55);
        wait_idle(200);
        idle(3);

        // Fill the FIFO behind a running frame and overflow it
        bus(1'b1, DIV, 32'd2);
        bus(1'b1, TXDATA, 32'($urandom));
        for (int i = 0; i < 17; i++) bus(1'b1, TXDATA, 32'($urandom));
        bus(1'b0, STATUS, 32'd0);
        bus(1'b1, STATUS, 32'h8);
        bus(1'b0, STATUS, 32'd0);
        wait_idle(1000);

        // Interrupt after the last frame, cleared by the next write
        bus(1'b1, CTRL, 32'd1);
        bus(1'b1, TXDATA, 32'hC3);
        wait_idle(200);
        idle(5);
        bus(1'b1, TXDATA, 32'h3C);
        wait_idle(200);
        idle(3);
        bus(1'b1, CTRL, 32'd0);

        // DIV of zero, and a DIV change in the middle of a frame
        bus(1'b1, DIV, 32'd0);
        bus(1'b0, DIV, 32'd0);
        bus(1'b1, DIV, 32'd2);
        bus(1'b1, TXDATA, 32'hA6);
        bus(1'b1, TXDATA, 32'h19);
        idle(5);
        bus(1'b1, DIV, 32'h0003);
        bus(1'b0, DIV, 32'd0);
        wait_idle(300);

        // Reset in the middle of the data bits
        bus(1'b1, DIV, 32'd4);
        bus(1'b1, TXDATA, 32'hA5);
        idle(12);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        bus(1'b0, STATUS, 32'd0);
        bus(1'b0, DIV, 32'd0);
        idle(2);

        // Random traffic
        bus(1'b1, DIV, 32'd1);
        for (int i = 0; i < 3000; i++) begin
            op = int'($urandom_range(0, 99));
            if (op < 40)      bus(1'b1, TXDATA, $urandom);
            else if (op < 52) bus(1'b0, 2'($urandom), $urandom);
            else if (op < 56) bus(1'b1, DIV, {$urandom_range(0, 65535) & 32'hFFFF0000} | 32'($urandom_range(0, 3)));
            else if (op < 61) bus(1'b1, CTRL, $urandom);
            else if (op < 66) bus(1'b1, STATUS, $urandom);
            else if (op < 68) begin
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
                bus(1'b1, DIV, 32'($urandom_range(1, 3)));
            end else begin
                idle(int'($urandom_range(1, 3)));
            end
        end
        wait_idle(2000);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
